// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral: prescaled 32-bit up-counter with
// compare match (auto-reload or one-shot), overflow flag and level interrupt.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        irq
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] SEL_CTRL     = 4'b1_000;
  localparam logic [3:0] SEL_COUNT    = 4'b1_001;
  localparam logic [3:0] SEL_COMPARE  = 4'b1_010;
  localparam logic [3:0] SEL_STATUS   = 4'b1_011;
  localparam logic [3:0] SEL_PRESCALE = 4'b1_100;

  logic [2:0]            ctrl_r,     ctrl_n_s;
  logic [31:0]           count_r,    count_n_s;
  logic [31:0]           compare_r,  compare_n_s;
  logic [1:0]            status_r,   status_n_s;
  logic [PRESCALE_W-1:0] prescale_r, prescale_n_s;
  logic [PRESCALE_W-1:0] pre_r,      pre_n_s;

  state_t     state_s;
  logic       hit_s;
  logic [3:0] wsel_s;
  logic [3:0] rsel_s;
  logic       tick_s;
  logic [1:0] set_s;
  logic       count_wr_s;
  logic       unused_s;

  assign hit_s      = (Address[31:5] == BASE_ADDR[31:5]);
  assign wsel_s     = {MemWrite & hit_s, Address[4:2]};
  assign rsel_s     = {hit_s, Address[4:2]};
  assign count_wr_s = (wsel_s == SEL_COUNT);
  assign unused_s   = ^Address[1:0];

  // The run/idle state is exactly the enable bit of CTRL.
  always_comb begin
    state_s = ctrl_r[0] ? RUN : IDLE;
  end

  // Next-state: prescaler tick, count/match/overflow, then CPU writes on top.
  always_comb begin
    ctrl_n_s     = ctrl_r;
    count_n_s    = count_r;
    compare_n_s  = compare_r;
    status_n_s   = status_r;
    prescale_n_s = prescale_r;
    pre_n_s      = pre_r;
    tick_s       = 1'b0;
    set_s        = 2'b00;

    case (state_s)
      RUN: begin
        if (pre_r == prescale_r) begin
          tick_s  = 1'b1;
          pre_n_s = {PRESCALE_W{1'b0}};
        end else begin
          tick_s  = 1'b0;
          pre_n_s = pre_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        tick_s  = 1'b0;
        pre_n_s = pre_r;
      end
    endcase

    // A CPU write to COUNT suppresses this cycle's match/overflow evaluation.
    if (tick_s && !count_wr_s) begin
      if (count_r == compare_r) begin
        set_s[0] = 1'b1;
        if (ctrl_r[1]) begin
          count_n_s = 32'd0;
        end else begin
          ctrl_n_s[0] = 1'b0;
        end
      end else begin
        count_n_s = count_r + 32'd1;
        set_s[1]  = (count_r == 32'hFFFF_FFFF);
      end
    end else begin
      set_s = 2'b00;
    end

    case (wsel_s)
      SEL_CTRL: begin
        ctrl_n_s = WriteData[2:0];
        pre_n_s  = WriteData[0] ? pre_n_s : {PRESCALE_W{1'b0}};
      end
      SEL_COUNT:    count_n_s    = WriteData;
      SEL_COMPARE:  compare_n_s  = WriteData;
      SEL_STATUS:   status_n_s   = status_r & ~WriteData[1:0];
      SEL_PRESCALE: prescale_n_s = WriteData[PRESCALE_W-1:0];
      default: ;
    endcase

    // Hardware set beats a same-cycle software clear.
    status_n_s = status_n_s | set_s;
  end

  // Register file update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r     <= 3'b000;
      count_r    <= 32'd0;
      compare_r  <= 32'hFFFF_FFFF;
      status_r   <= 2'b00;
      prescale_r <= {PRESCALE_W{1'b0}};
      pre_r      <= {PRESCALE_W{1'b0}};
    end else begin
      ctrl_r     <= ctrl_n_s;
      count_r    <= count_n_s;
      compare_r  <= compare_n_s;
      status_r   <= status_n_s;
      prescale_r <= prescale_n_s;
      pre_r      <= pre_n_s;
    end
  end

  // Zero-latency read decode; anything outside the window reads 0.
  always_comb begin
    ReadData = 32'd0;
    case (rsel_s)
      SEL_CTRL:     ReadData = {29'd0, ctrl_r};
      SEL_COUNT:    ReadData = count_r;
      SEL_COMPARE:  ReadData = compare_r;
      SEL_STATUS:   ReadData = {30'd0, status_r};
      SEL_PRESCALE: ReadData = {{(32-PRESCALE_W){1'b0}}, prescale_r};
      default:      ReadData = 32'd0;
    endcase
  end

  assign Hit = hit_s;
  assign irq = status_r[0] & ctrl_r[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: per-cycle comparison against a
// behavioural register model plus directed literal checks.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic        irq;

  int tests = 0;
  int fails = 0;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        ar;
    logic        ie;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic        ovf;
    logic [15:0] ps;
    logic [15:0] pre;
  } ms_t;

  ms_t m;
  bit  started = 1'b0;

  function automatic ms_t rst_state();
    ms_t r;
    r     = '0;
    r.cmp = 32'hFFFF_FFFF;
    return r;
  endfunction

  // One clock edge of the timer as described by its register-level rules.
  function automatic ms_t step(ms_t s, logic rst, logic we, logic [31:0] a, logic [31:0] d);
    ms_t         n;
    bit          w;
    int unsigned off;
    bit          tick;
    logic [32:0] inc;
    bit          set_m;
    bit          set_o;
    if (rst) return rst_state();
    n     = s;
    set_m = 1'b0;
    set_o = 1'b0;
    w     = we && (a[31:5] == BASE[31:5]);
    off   = a[4:2];
    tick  = s.en && (s.pre == s.ps);
    if (s.en) n.pre = tick ? 16'd0 : s.pre + 16'd1;
    if (tick && !(w && off == 1)) begin
      if (s.count == s.cmp) begin
        set_m = 1'b1;
        if (s.ar) n.count = 32'd0;
        else n.en = 1'b0;
      end else begin
        inc     = {1'b0, s.count} + 33'd1;
        n.count = inc[31:0];
        set_o   = inc[32];
      end
    end
    if (w) begin
      case (off)
        0: begin
          n.en = d[0]; n.ar = d[1]; n.ie = d[2];
          if (!d[0]) n.pre = 16'd0;
        end
        1: n.count = d;
        2: n.cmp = d;
        3: begin
          if (d[0]) n.match = 1'b0;
          if (d[1]) n.ovf = 1'b0;
        end
        4: n.ps = d[15:0];
        default: ;
      endcase
    end
    if (set_m) n.match = 1'b1;
    if (set_o) n.ovf = 1'b1;
    return n;
  endfunction

  function automatic logic [31:0] mread(ms_t s, logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:2])
      3'd0: return {29'd0, s.ie, s.ar, s.en};
      3'd1: return s.count;
      3'd2: return s.cmp;
      3'd3: return {30'd0, s.ovf, s.match};
      3'd4: return {16'd0, s.ps};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edge as the DUT.
  always @(posedge clk) begin
    m <= step(m, reset, MemWrite, Address, WriteData);
    if (reset) started <= 1'b1;
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      check("model_hit", {31'd0, Hit}, {31'd0, (Address[31:5] == BASE[31:5])});
      check("model_rdata", ReadData, mread(m, Address));
      check("model_irq", {31'd0, irq}, {31'd0, m.match & m.ie});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    Address   = BASE + off;
    WriteData = d;
    MemWrite  = 1'b1;
    cyc();
    MemWrite  = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [31:0] off, input logic [31:0] exp);
    Address = BASE + off;
    #1;
    check(name, ReadData, exp);
  endtask

  logic [31:0] seq2 [5] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
  logic [31:0] seq3 [8] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};

  initial begin
    reset = 1'b1; MemWrite = 1'b0; Address = BASE; WriteData = 32'd0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset values and out-of-window read
    rdchk("rst_ctrl", 32'h00, 32'd0);
    rdchk("rst_count", 32'h04, 32'd0);
    rdchk("rst_compare", 32'h08, 32'hFFFF_FFFF);
    cyc();
    rdchk("rst_status", 32'h0C, 32'd0);
    rdchk("rst_prescale", 32'h10, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    cyc();
    Address = BASE + 32'h20;
    #1;
    check("oow_hit", {31'd0, Hit}, 32'd0);
    check("oow_rdata", ReadData, 32'd0);

    // Auto-reload, prescale 0, compare 3
    wr(32'h10, 32'd0); wr(32'h08, 32'd3); wr(32'h00, 32'd7);
    for (int i = 0; i < 5; i++) begin
      cyc();
      rdchk("ar_count", 32'h04, seq2[i]);
      if (i == 3) begin
        rdchk("ar_status", 32'h0C, 32'd1);
        check("ar_irq", {31'd0, irq}, 32'd1);
      end
    end
    wr(32'h00, 32'd6); wr(32'h0C, 32'd1);
    rdchk("w1c_status", 32'h0C, 32'd0);
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // One-shot, prescale 2, compare 1
    wr(32'h04, 32'd0); wr(32'h10, 32'd2); wr(32'h08, 32'd1); wr(32'h00, 32'd1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      rdchk("os_count", 32'h04, seq3[k]);
      if (k == 5) begin
        rdchk("os_ctrl", 32'h00, 32'd0);
        rdchk("os_status", 32'h0C, 32'd1);
      end
    end
    repeat (10) cyc();
    rdchk("os_hold", 32'h04, 32'd1);

    // Overflow wrap
    wr(32'h0C, 32'd3); wr(32'h04, 32'hFFFF_FFFE); wr(32'h08, 32'd5);
    wr(32'h10, 32'd0); wr(32'h00, 32'd3);
    cyc();
    rdchk("ovf_count_max", 32'h04, 32'hFFFF_FFFF);
    cyc();
    rdchk("ovf_count_zero", 32'h04, 32'd0);
    rdchk("ovf_status", 32'h0C, 32'd2);

    // Collision: W1C on the match-set cycle
    wr(32'h00, 32'd0); wr(32'h0C, 32'd3); wr(32'h04, 32'd0); wr(32'h08, 32'd2);
    wr(32'h00, 32'd3);
    cyc(); cyc();
    wr(32'h0C, 32'd1);
    rdchk("col_w1c_status", 32'h0C, 32'd1);
    rdchk("col_w1c_count", 32'h04, 32'd0);

    // Collision: COUNT write on a tick cycle with prescale 2
    wr(32'h00, 32'd0); wr(32'h0C, 32'd3); wr(32'h10, 32'd2); wr(32'h08, 32'd1000);
    wr(32'h04, 32'd0); wr(32'h00, 32'd1);
    cyc(); cyc();
    wr(32'h04, 32'd100);
    rdchk("col_cnt_wr", 32'h04, 32'd100);
    cyc(); cyc();
    rdchk("col_cnt_hold", 32'h04, 32'd100);
    cyc();
    rdchk("col_cnt_next", 32'h04, 32'd101);

    // Reset mid-run with COUNT=7, STATUS=3; COMPARE write on a tick uses old value
    wr(32'h00, 32'd0); wr(32'h0C, 32'd3); wr(32'h10, 32'd0);
    wr(32'h04, 32'hFFFF_FFFF); wr(32'h08, 32'd0); wr(32'h00, 32'd3);
    cyc();
    wr(32'h08, 32'd1000);
    rdchk("pre_rst_status", 32'h0C, 32'd3);
    wr(32'h04, 32'd7);
    rdchk("pre_rst_count", 32'h04, 32'd7);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rdchk("post_rst_ctrl", 32'h00, 32'd0);
    rdchk("post_rst_count", 32'h04, 32'd0);
    rdchk("post_rst_compare", 32'h08, 32'hFFFF_FFFF);
    cyc();
    rdchk("post_rst_status", 32'h0C, 32'd0);
    rdchk("post_rst_prescale", 32'h10, 32'd0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) cyc();
    rdchk("post_rst_stopped", 32'h04, 32'd0);

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
